// File: rtl/mc_control_pkg.sv
// mc_control_pkg: state encoding, opcodes and datapath select encodings for the multi-cycle control unit
package mc_control_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RWB, S_ADDIEX, S_IWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_control_retire_counter.sv
// retire_counter: wrapping retired-instruction counter with synchronous clear
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main control FSM with memory stall handshake, illegal-opcode trap and retire count
module mc_control
  import mc_control_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32,
  parameter bit TRAP_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                Ne,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);
  state_t r_state, w_next, w_dec;
  logic [OPCODE_W-1:0] r_op;
  logic [5:0] w_op, w_rop;
  logic w_inc;
  assign w_op  = 6'(opcode);
  assign w_rop = 6'(r_op);
  assign w_dec = (w_op == OP_RTYPE)                 ? S_EXEC   :
                 (w_op == OP_LW || w_op == OP_SW)   ? S_MEMADR :
                 (w_op == OP_BEQ || w_op == OP_BNE) ? S_BRANCH :
                 (w_op == OP_ADDI)                  ? S_ADDIEX :
                 (w_op == OP_J)                     ? S_JUMP   :
                 TRAP_EN                            ? S_TRAP   : S_FETCH;
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_dec;
      S_MEMADR: w_next = (w_rop == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RWB;
      S_ADDIEX: w_next = S_IWB;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode;
    end
  end
  // a stalled FETCH is not a new entry; IDLE->FETCH starts the first instruction
  assign w_inc = rst_n && w_next == S_FETCH && r_state != S_FETCH && r_state != S_IDLE;
  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk  (clk),
    .i_clr(!rst_n),
    .i_inc(w_inc),
    .o_cnt(retired)
  );
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; Ne = 1'b0; IorD = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0;
    RegDst = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0; illegal = 1'b0;
    ALUSrcB = SRCB_B; ALUOp = ALU_ADD; PCSource = PC_ALU;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1; ALUSrcB = SRCB_4;
        PCWrite = mem_ready; IRWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM4;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1; IorD = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1; MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1; IorD = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1; ALUOp = ALU_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1; RegDst = 1'b1;
      end
      S_IWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 1'b1; ALUOp = ALU_SUB; PCWriteCond = 1'b1;
        PCSource = PC_ALUOUT; Ne = (w_rop == OP_BNE);
      end
      S_JUMP: begin
        PCWrite = 1'b1; PCSource = PC_JUMP;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed scoreboard bench; dut A traps with a 4-bit counter, dut B retires illegal opcodes as NOPs
module tb_mc_control;
  localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6,
                 EXEC = 7, RWB = 8, ADDIEX = 9, IWB = 10, BRANCH = 11, JUMP = 12, TRAP = 13;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
  typedef struct {int step; int dut; int st; logic mr; logic ne; longint ret;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  wire [17:0] va, vb;
  wire [3:0] ret_a;
  wire [31:0] ret_b;
  exp_t q[$];
  exp_t e;
  int step = 0, bst = -1, n_checks = 0, n_fail = 0;
  longint bret = 0, act_ret;
  logic [17:0] act_v, exp_v;
  always #5 clk = ~clk;
  mc_control #(.OPCODE_W(6), .CNT_W(4), .TRAP_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(va[17]), .PCWriteCond(va[16]), .Ne(va[15]), .IorD(va[14]), .MemRead(va[13]),
    .MemWrite(va[12]), .IRWrite(va[11]), .MemtoReg(va[10]), .RegDst(va[9]), .RegWrite(va[8]),
    .ALUSrcA(va[7]), .ALUSrcB(va[6:5]), .ALUOp(va[4:3]), .PCSource(va[2:1]), .illegal(va[0]),
    .retired(ret_a));
  mc_control #(.OPCODE_W(6), .CNT_W(32), .TRAP_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(vb[17]), .PCWriteCond(vb[16]), .Ne(vb[15]), .IorD(vb[14]), .MemRead(vb[13]),
    .MemWrite(vb[12]), .IRWrite(vb[11]), .MemtoReg(vb[10]), .RegDst(vb[9]), .RegWrite(vb[8]),
    .ALUSrcA(vb[7]), .ALUSrcB(vb[6:5]), .ALUOp(vb[4:3]), .PCSource(vb[2:1]), .illegal(vb[0]),
    .retired(ret_b));
  function automatic logic [17:0] ctl(int st, logic mr, logic ne);
    logic [17:0] v = '0;
    case (st)
      FETCH: begin v[13] = 1'b1; v[6:5] = 2'b01; v[17] = mr; v[11] = mr; end
      DECODE: v[6:5] = 2'b11;
      MEMADR, ADDIEX: begin v[7] = 1'b1; v[6:5] = 2'b10; end
      MEMRD: begin v[13] = 1'b1; v[14] = 1'b1; end
      MEMWB: begin v[8] = 1'b1; v[10] = 1'b1; end
      MEMWR: begin v[12] = 1'b1; v[14] = 1'b1; end
      EXEC: begin v[7] = 1'b1; v[4:3] = 2'b10; end
      RWB: begin v[8] = 1'b1; v[9] = 1'b1; end
      IWB: v[8] = 1'b1;
      BRANCH: begin v[7] = 1'b1; v[4:3] = 2'b01; v[16] = 1'b1; v[2:1] = 2'b01; v[15] = ne; end
      JUMP: begin v[17] = 1'b1; v[2:1] = 2'b10; end
      TRAP: v[0] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction
  // one call = one clock cycle: inputs for this cycle plus the state/count expected during it
  task automatic cyc(input logic rn, input logic [5:0] op, input logic mr, input int st,
                     input longint ret, input logic ne = 1'b0);
    rst_n = rn; opcode = op; mem_ready = mr; step++;
    q.push_back('{step, 0, st, mr, ne, ret});
    if (bst >= 0) q.push_back('{step, 1, bst, mr, 1'b0, bret});
    bst = -1;
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      act_v = e.dut != 0 ? vb : va;
      act_ret = e.dut != 0 ? longint'(ret_b) : longint'(ret_a);
      exp_v = ctl(e.st, e.mr, e.ne);
      n_checks += 2;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL ctl step=%0d dut=%0d state=%0d got=%b exp=%b", e.step, e.dut, e.st, act_v, exp_v);
      end
      if (act_ret !== e.ret) begin
        n_fail++;
        $display("FAIL retired step=%0d dut=%0d state=%0d got=%0d exp=%0d", e.step, e.dut, e.st, act_ret, e.ret);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc(0, R, 0, IDLE, 0);
    cyc(1, R, 1, IDLE, 0);
    cyc(1, R, 1, FETCH, 0);
    cyc(1, R, 1, DECODE, 0);
    cyc(1, BAD, 1, EXEC, 0);
    cyc(1, BAD, 1, RWB, 0);
    cyc(1, R, 0, FETCH, 1);
    cyc(1, R, 0, FETCH, 1);
    cyc(1, R, 1, FETCH, 1);
    cyc(1, LW, 1, DECODE, 1);
    cyc(1, SW, 1, MEMADR, 1);
    cyc(1, SW, 0, MEMRD, 1);
    cyc(1, SW, 0, MEMRD, 1);
    cyc(1, SW, 1, MEMRD, 1);
    cyc(1, SW, 0, MEMWB, 1);
    cyc(1, R, 1, FETCH, 2);
    cyc(1, BNE, 1, DECODE, 2);
    cyc(1, BEQ, 1, BRANCH, 2, 1'b1);
    cyc(1, R, 1, FETCH, 3);
    cyc(1, BEQ, 1, DECODE, 3);
    cyc(1, BNE, 1, BRANCH, 3, 1'b0);
    cyc(1, R, 1, FETCH, 4);
    cyc(1, SW, 1, DECODE, 4);
    cyc(1, LW, 1, MEMADR, 4);
    cyc(1, LW, 0, MEMWR, 4);
    cyc(1, LW, 1, MEMWR, 4);
    cyc(1, R, 1, FETCH, 5);
    cyc(1, ADDI, 1, DECODE, 5);
    cyc(1, R, 1, ADDIEX, 5);
    cyc(1, R, 1, IWB, 5);
    cyc(1, R, 1, FETCH, 6);
    cyc(1, SW, 1, DECODE, 6);
    cyc(1, R, 1, MEMADR, 6);
    cyc(0, R, 0, MEMWR, 6);
    cyc(1, R, 1, IDLE, 0);
    for (int k = 0; k < 16; k++) begin
      cyc(1, R, 1, FETCH, k);
      cyc(1, J, 1, DECODE, k);
      cyc(1, R, 1, JUMP, k);
    end
    bst = FETCH; bret = 16;
    cyc(1, R, 1, FETCH, 0);
    bst = DECODE; bret = 16;
    cyc(1, BAD, 1, DECODE, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin bst = FETCH; bret = 17; end
      if (i == 1) begin bst = DECODE; bret = 17; end
      if (i == 2) begin bst = FETCH; bret = 18; end
      cyc(1, BAD, 1, TRAP, 0);
    end
    cyc(0, BAD, 1, TRAP, 0);
    cyc(1, R, 0, IDLE, 0);
    cyc(1, R, 0, FETCH, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
